// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed 7-segment scanner with a one-deep pending register and a sticky bad-digit flag.
// Optional leading-zero blanking of the tens digit is enabled by defining BCD_SCAN_BLANK_LZ_EN.
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       err
);

    // state   | meaning
    // S_TENS  | tens digit driven, dig_en=10
    // S_UNITS | units digit driven, dig_en=01; last count of this state is the frame end
    typedef enum logic {
        S_TENS  = 1'b0,
        S_UNITS = 1'b1
    } state_t;

    localparam logic [15:0] CNT_TC = 16'(REFRESH_DIV - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_pend_valid;
    logic [3:0]  r_pend_tens;
    logic [3:0]  r_pend_units;
    logic [3:0]  r_disp_tens;
    logic [3:0]  r_disp_units;
    logic        r_err;
    logic [6:0]  r_seg;
    logic [1:0]  r_dig_en;

    logic        w_accept;
    logic        w_cnt_tc;
    logic        w_frame_end;
    logic        w_bad_digit;
    logic [6:0]  w_seg_nxt;
    logic [1:0]  w_dig_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h7E;
            4'd1:    f_decode = 7'h30;
            4'd2:    f_decode = 7'h6D;
            4'd3:    f_decode = 7'h79;
            4'd4:    f_decode = 7'h33;
            4'd5:    f_decode = 7'h5B;
            4'd6:    f_decode = 7'h5F;
            4'd7:    f_decode = 7'h70;
            4'd8:    f_decode = 7'h7F;
            4'd9:    f_decode = 7'h7B;
            default: f_decode = 7'h00;
        endcase
    endfunction

    assign in_ready    = ~r_pend_valid;
    assign w_accept    = in_valid & ~r_pend_valid;
    assign w_cnt_tc    = (r_cnt == CNT_TC);
    assign w_frame_end = (r_state == S_UNITS) && w_cnt_tc;
    assign w_bad_digit = (tens > 4'd9) || (units > 4'd9);

    always_comb begin
        w_seg_nxt = 7'h00;
        w_dig_nxt = 2'b00;
        if (r_state == S_TENS) begin
`ifdef BCD_SCAN_BLANK_LZ_EN
            if (r_disp_tens != 4'd0) begin
                w_seg_nxt = f_decode(r_disp_tens);
                w_dig_nxt = 2'b10;
            end
`else
            w_seg_nxt = f_decode(r_disp_tens);
            w_dig_nxt = 2'b10;
`endif
        end else begin
            w_seg_nxt = f_decode(r_disp_units);
            w_dig_nxt = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_TENS;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_tens  <= '0;
            r_pend_units <= '0;
            r_disp_tens  <= '0;
            r_disp_units <= '0;
            r_err        <= 1'b0;
            r_seg        <= '0;
            r_dig_en     <= '0;
        end else begin
            if (w_cnt_tc) begin
                r_cnt <= '0;
                if (r_state == S_TENS) r_state <= S_UNITS;
                else                   r_state <= S_TENS;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            // A fresh acceptance at frame end stays pending; only an already-pending pair transfers.
            if (w_frame_end && r_pend_valid) begin
                r_disp_tens  <= r_pend_tens;
                r_disp_units <= r_pend_units;
                r_pend_valid <= 1'b0;
            end else if (w_accept) begin
                r_pend_tens  <= tens;
                r_pend_units <= units;
                r_pend_valid <= 1'b1;
            end

            if (w_accept && w_bad_digit) r_err <= 1'b1;

            r_seg    <= w_seg_nxt;
            r_dig_en <= w_dig_nxt;
        end
    end

    assign seg    = r_seg;
    assign dig_en = r_dig_en;
    assign err    = r_err;

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter: REFRESH_DIV, 4, clock cycles each digit is driven; legal range 2..65535.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  tens/units pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept a pair.
REQ-006 SHALL have port: tens  input  4  BCD tens digit from the upstream binary-to-BCD converter.
REQ-007 SHALL have port: units  input  4  BCD units digit from the upstream converter.
REQ-008 SHALL have port: seg  output  7  active-high segments, bit6=a through bit0=g.
REQ-009 SHALL have port: dig_en  output  2  one-hot digit enable, bit1=tens, bit0=units, active-high.
REQ-010 SHALL have port: err  output  1  sticky flag, set when an accepted digit is greater than 9.

Function
REQ-011 SHALL accept a pair on any rising edge where in_valid=1 and in_ready=1, storing it in a pending register.
REQ-012 SHALL drive in_ready = NOT pending_valid.
REQ-013 SHALL use a two-state scan FSM, TENS -> UNITS -> TENS, with a divider counter running 0..REFRESH_DIV-1.
REQ-014 SHALL advance the FSM state and restart the counter at 0 when the counter equals REFRESH_DIV-1.
REQ-015 SHALL define frame end as state UNITS with counter = REFRESH_DIV-1.
REQ-016 SHALL, at frame end with pending_valid=1, copy pending into the display register and clear pending_valid; in_ready SHALL read 1 on the following cycle.
REQ-017 SHALL, when an acceptance coincides with a frame end while pending is empty, store the pair in pending only; it SHALL transfer at the next frame end.
REQ-018 SHALL register seg and dig_en, so outputs reflect the FSM state and display register with exactly one cycle of latency.
REQ-019 SHALL set dig_en=10 in TENS and 01 in UNITS; both bits are never high simultaneously.
REQ-020 SHALL decode digits 0-9 to the segment patterns 7E,30,6D,79,33,5B,5F,70,7F,7B (hex).
REQ-021 SHALL drive seg=00 for a displayed digit greater than 9, with dig_en unchanged.
REQ-022 SHALL set err on the edge that accepts tens>9 or units>9; err SHALL clear only on reset.
REQ-023 SHALL not allow the input handshake to stall, skip or stretch the scan timing.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, set: FSM=TENS, counter=0, display=00, pending_valid=0, in_ready=1, err=0, seg=00, dig_en=00.
REQ-025 SHALL discard pending and display contents on reset asserted mid-frame; the first cycle after release SHALL show dig_en=00, then dig_en=10 with seg=7E.

Configuration
REQ-026 SHALL provide leading-zero blanking when macro BCD_SCAN_BLANK_LZ_EN is defined: a displayed tens digit of 0 drives seg=00 and dig_en=00 during TENS, with timing unchanged.
REQ-027 SHALL, without BCD_SCAN_BLANK_LZ_EN, display a tens digit of 0 as seg=7E with dig_en=10.

Verification (REFRESH_DIV=4)
REQ-028 SHALL cover idle after reset: no input -> dig_en alternates 10 for 4 cycles then 01 for 4 cycles, seg=7E throughout, in_ready=1.
REQ-029 SHALL cover a single update: accept tens=1, units=5 -> in_ready=0 until the frame end, then TENS shows seg=30 and UNITS shows seg=5B.
REQ-030 SHALL cover back-pressure: in_valid held high with 0/9 while pending is full -> not accepted until the cycle after transfer; display shows 0/9 one frame later.
REQ-031 SHALL cover invalid input: accept tens=0, units=C -> err=1 and remains 1; UNITS shows seg=00.
REQ-032 SHALL cover reset mid-UNITS with a pair pending -> all outputs equal the reset values; the pending pair is never displayed.
REQ-033 SHALL cover the macro build: with BCD_SCAN_BLANK_LZ_EN defined, tens=0, units=7 -> TENS shows dig_en=00, seg=00; UNITS shows dig_en=01, seg=70.
